// File: rtl/ram_ctrl_pkg.sv
// Shared types and constants for the RAM request controller.
package ram_ctrl_pkg;

    localparam int RAM_DATA_W = 16;

    // Byte-lane enables: [1] = bits 15:8, [0] = bits 7:0.
    localparam logic [1:0] BE_NONE = 2'b00;
    localparam logic [1:0] BE_LO   = 2'b01;
    localparam logic [1:0] BE_HI   = 2'b10;
    localparam logic [1:0] BE_WORD = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RDW,
        MRG,
        WR
    } state_t;

endpackage

// File: rtl/ram_byte_ctrl_merge.sv
// Lane merge for read-modify-write: enabled lanes take the new word,
// disabled lanes keep the word read back from the RAM.
module byte_merge
    import ram_ctrl_pkg::*;
(
    input  logic [RAM_DATA_W-1:0] old_word,
    input  logic [RAM_DATA_W-1:0] new_word,
    input  logic [1:0]            be,
    output logic [RAM_DATA_W-1:0] merged
);

    assign merged[15:8] = be[1] ? new_word[15:8] : old_word[15:8];
    assign merged[7:0]  = be[0] ? new_word[7:0]  : old_word[7:0];

endmodule

// File: rtl/ram_byte_ctrl.sv
// Request controller in front of a 4096x16 synchronous RAM. Sequences
// chip-select / write-enable, does read-modify-write for single-byte
// writes and returns read data with a one-cycle response pulse.
module ram_byte_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  REQ_VALID,
    output logic                  REQ_READY,
    input  logic                  REQ_WE,
    input  logic [1:0]            REQ_BE,
    input  logic [ADDR_W-1:0]     REQ_ADDR,
    input  logic [RAM_DATA_W-1:0] REQ_WDATA,
    output logic                  RSP_VALID,
    output logic [RAM_DATA_W-1:0] RSP_RDATA,
    output logic                  RAM_nCS,
    output logic                  RAM_nWE,
    output logic [ADDR_W-1:0]     RAM_ADDR,
    output logic [RAM_DATA_W-1:0] RAM_DI,
    input  logic [RAM_DATA_W-1:0] RAM_DO
);

    state_t                state, state_nx;

    // Latched request fields needed after acceptance (address lives in RAM_ADDR).
    logic                  lat_we, lat_we_nx;
    logic [1:0]            lat_be, lat_be_nx;
    logic [RAM_DATA_W-1:0] lat_wdata, lat_wdata_nx;

    logic                  ncs_nx, nwe_nx, rsp_valid_nx;
    logic [ADDR_W-1:0]     addr_nx;
    logic [RAM_DATA_W-1:0] di_nx, rdata_nx;
    logic [RAM_DATA_W-1:0] merged;

    byte_merge u_merge (
        .old_word (RAM_DO),
        .new_word (lat_wdata),
        .be       (lat_be),
        .merged   (merged)
    );

    // Only the idle state takes requests; held off while reset is applied.
    assign REQ_READY = (state == IDLE) && !RESET;

    // Next-state and next-output decode; strobes default high so each
    // access pulses them for exactly one cycle.
    always_comb begin
        state_nx     = state;
        ncs_nx       = 1'b1;
        nwe_nx       = 1'b1;
        addr_nx      = RAM_ADDR;
        di_nx        = RAM_DI;
        rsp_valid_nx = 1'b0;
        rdata_nx     = RSP_RDATA;
        lat_we_nx    = lat_we;
        lat_be_nx    = lat_be;
        lat_wdata_nx = lat_wdata;

        case (state)
            IDLE: begin
                if (REQ_VALID && REQ_READY) begin
                    lat_we_nx    = REQ_WE;
                    lat_be_nx    = REQ_BE;
                    lat_wdata_nx = REQ_WDATA;
                    if (!REQ_WE) begin
                        state_nx = RD;
                        ncs_nx   = 1'b0;
                        addr_nx  = REQ_ADDR;
                    end else if (REQ_BE == BE_WORD) begin
                        state_nx = WR;
                        ncs_nx   = 1'b0;
                        nwe_nx   = 1'b0;
                        addr_nx  = REQ_ADDR;
                        di_nx    = REQ_WDATA;
                    end else if (REQ_BE != BE_NONE) begin
                        // Single-byte write: fetch the old word first.
                        state_nx = RD;
                        ncs_nx   = 1'b0;
                        addr_nx  = REQ_ADDR;
                    end
                    // An empty byte mask touches nothing and stays idle.
                end
            end
            RD: state_nx = RDW;
            RDW: begin
                if (lat_we) begin
                    // Merge happens here so the write strobe follows directly.
                    state_nx = WR;
                    ncs_nx   = 1'b0;
                    nwe_nx   = 1'b0;
                    di_nx    = merged;
                end else begin
                    state_nx     = IDLE;
                    rsp_valid_nx = 1'b1;
                    rdata_nx     = RAM_DO;
                end
            end
            // MRG is never entered by the current sequence; recover to idle.
            MRG:     state_nx = IDLE;
            WR:      state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State and registered outputs; reset aborts any access in flight.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= IDLE;
            RAM_nCS   <= 1'b1;
            RAM_nWE   <= 1'b1;
            RAM_ADDR  <= '0;
            RAM_DI    <= '0;
            RSP_VALID <= 1'b0;
            RSP_RDATA <= '0;
            lat_we    <= 1'b0;
            lat_be    <= BE_NONE;
            lat_wdata <= '0;
        end else begin
            state     <= state_nx;
            RAM_nCS   <= ncs_nx;
            RAM_nWE   <= nwe_nx;
            RAM_ADDR  <= addr_nx;
            RAM_DI    <= di_nx;
            RSP_VALID <= rsp_valid_nx;
            RSP_RDATA <= rdata_nx;
            lat_we    <= lat_we_nx;
            lat_be    <= lat_be_nx;
            lat_wdata <= lat_wdata_nx;
        end
    end

endmodule

// File: tb/tb_ram_byte_ctrl.sv
// Bench for ram_byte_ctrl: behavioural RAM plus a word-level reference memory.
module tb_ram_byte_ctrl;

    localparam int ADDR_W = 12;

    logic              CLK = 1'b0;
    logic              RESET;
    logic              REQ_VALID;
    logic              REQ_READY;
    logic              REQ_WE;
    logic [1:0]        REQ_BE;
    logic [ADDR_W-1:0] REQ_ADDR;
    logic [15:0]       REQ_WDATA;
    logic              RSP_VALID;
    logic [15:0]       RSP_RDATA;
    logic              RAM_nCS;
    logic              RAM_nWE;
    logic [ADDR_W-1:0] RAM_ADDR;
    logic [15:0]       RAM_DI;
    logic [15:0]       ram_do = 16'h0;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] mem [0:4095] = '{default: 16'h0};
    logic [15:0] ref_mem [0:4095];
    logic [15:0] last_rd;
    int cs_cnt = 0;
    int we_cnt = 0;

    always #5 CLK = ~CLK;

    ram_byte_ctrl #(.ADDR_W(ADDR_W)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .REQ_VALID (REQ_VALID),
        .REQ_READY (REQ_READY),
        .REQ_WE    (REQ_WE),
        .REQ_BE    (REQ_BE),
        .REQ_ADDR  (REQ_ADDR),
        .REQ_WDATA (REQ_WDATA),
        .RSP_VALID (RSP_VALID),
        .RSP_RDATA (RSP_RDATA),
        .RAM_nCS   (RAM_nCS),
        .RAM_nWE   (RAM_nWE),
        .RAM_ADDR  (RAM_ADDR),
        .RAM_DI    (RAM_DI),
        .RAM_DO    (ram_do)
    );

    // Synchronous RAM; also counts chip-select and write strobes.
    always @(posedge CLK) begin
        if (!RAM_nCS) begin
            cs_cnt <= cs_cnt + 1;
            if (!RAM_nWE) begin
                mem[RAM_ADDR] <= RAM_DI;
                we_cnt <= we_cnt + 1;
            end else begin
                ram_do <= mem[RAM_ADDR];
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // One request; checks latency, strobe counts, response and memory contents.
    task automatic xfer(input logic we, input logic [1:0] be, input logic [ADDR_W-1:0] addr,
                        input logic [15:0] wdata, input string tag);
        int cs0, we0, k, rsp_n, rsp_at, exp_lat, exp_cs, exp_we;
        logic [15:0] got, exp_rd, mask;
        exp_rd = ref_mem[addr];
        if (!we)              begin exp_lat = 3; exp_cs = 1; exp_we = 0; end
        else if (be == 2'b11) begin exp_lat = 2; exp_cs = 1; exp_we = 1; end
        else if (be == 2'b00) begin exp_lat = 1; exp_cs = 0; exp_we = 0; end
        else                  begin exp_lat = 4; exp_cs = 2; exp_we = 1; end
        REQ_VALID = 1'b1; REQ_WE = we; REQ_BE = be; REQ_ADDR = addr; REQ_WDATA = wdata;
        k = 0;
        while (!REQ_READY && k < 20) begin step(); k++; end
        vectors++;
        if (REQ_READY !== 1'b1) begin
            miscompares++;
            $display("FAIL %s accept: ready=%b required 1", tag, REQ_READY);
            REQ_VALID = 1'b0;
            return;
        end
        cs0 = cs_cnt; we0 = we_cnt;
        step();
        REQ_VALID = 1'b0;
        k = 1; rsp_n = 0; rsp_at = 0; got = '0;
        forever begin
            if (RSP_VALID) begin rsp_n++; rsp_at = k; got = RSP_RDATA; end
            if (REQ_READY || k >= 10) break;
            step(); k++;
        end
        vectors++;
        if (k !== exp_lat) begin miscompares++;
            $display("FAIL %s latency: got %0d required %0d", tag, k, exp_lat); end
        vectors++;
        if (cs_cnt - cs0 !== exp_cs) begin miscompares++;
            $display("FAIL %s ncs_pulses: got %0d required %0d", tag, cs_cnt - cs0, exp_cs); end
        vectors++;
        if (we_cnt - we0 !== exp_we) begin miscompares++;
            $display("FAIL %s nwe_pulses: got %0d required %0d", tag, we_cnt - we0, exp_we); end
        if (!we) begin
            vectors++;
            if (rsp_n !== 1 || rsp_at !== 3) begin miscompares++;
                $display("FAIL %s rsp_timing: count %0d at %0d required 1 at 3", tag, rsp_n, rsp_at); end
            vectors++;
            if (got !== exp_rd) begin miscompares++;
                $display("FAIL %s rdata @%h: got %h required %h", tag, addr, got, exp_rd); end
            last_rd = exp_rd;
            step();
            vectors++;
            if (RSP_VALID !== 1'b0) begin miscompares++;
                $display("FAIL %s rsp_width: rsp_valid=%b required 0", tag, RSP_VALID); end
        end else begin
            vectors++;
            if (rsp_n !== 0) begin miscompares++;
                $display("FAIL %s write_rsp: count %0d required 0", tag, rsp_n); end
            vectors++;
            if (RSP_RDATA !== last_rd) begin miscompares++;
                $display("FAIL %s rdata_hold: got %h required %h", tag, RSP_RDATA, last_rd); end
            mask = {{8{be[1]}}, {8{be[0]}}};
            ref_mem[addr] = (ref_mem[addr] & ~mask) | (wdata & mask);
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1; REQ_VALID = 1'b0; REQ_WE = 1'b0; REQ_BE = 2'b00;
        REQ_ADDR = '0; REQ_WDATA = '0;
        step(); step(); step();
        vectors++;
        if ({RAM_nCS, RAM_nWE, RSP_VALID, REQ_READY} !== 4'b1100) begin miscompares++;
            $display("FAIL reset_ctrl: ncs/nwe/rsp/ready=%b required 1100",
                     {RAM_nCS, RAM_nWE, RSP_VALID, REQ_READY}); end
        vectors++;
        if (RAM_ADDR !== '0 || RAM_DI !== '0 || RSP_RDATA !== '0) begin miscompares++;
            $display("FAIL reset_data: addr=%h di=%h rdata=%h required 0", RAM_ADDR, RAM_DI, RSP_RDATA); end
        RESET = 1'b0;
        #1;
        vectors++;
        if (REQ_READY !== 1'b1) begin miscompares++;
            $display("FAIL reset_release: ready=%b required 1", REQ_READY); end
        last_rd = 16'h0;
    endtask

    task automatic test_full_write_read();
        xfer(1'b1, 2'b11, 12'h005, 16'h1234, "full_wr");
        xfer(1'b0, 2'b11, 12'h005, 16'h0000, "full_rd");
    endtask

    task automatic test_partial_writes();
        xfer(1'b1, 2'b11, 12'h010, 16'hAABB, "hi_pre");
        xfer(1'b1, 2'b10, 12'h010, 16'hCC00, "hi_wr");
        xfer(1'b0, 2'b01, 12'h010, 16'h0000, "hi_rd");
        xfer(1'b1, 2'b11, 12'h011, 16'hAABB, "lo_pre");
        xfer(1'b1, 2'b01, 12'h011, 16'h00DD, "lo_wr");
        xfer(1'b0, 2'b00, 12'h011, 16'h0000, "lo_rd");
        xfer(1'b1, 2'b00, 12'h011, 16'hFFFF, "none_wr");
        xfer(1'b0, 2'b11, 12'h011, 16'h0000, "none_rd");
    endtask

    task automatic test_back_to_back();
        int issued, cyc;
        int acc_cyc[4];
        int rsp_cyc[$];
        logic [15:0] rsp_dat[$];
        logic accepting;
        for (int i = 0; i < 4; i++)
            xfer(1'b1, 2'b11, ADDR_W'(i), 16'(16'h1111 * (i + 1)), "b2b_pre");
        issued = 0; cyc = 0;
        REQ_VALID = 1'b1; REQ_WE = 1'b0; REQ_BE = 2'($urandom_range(0, 3)); REQ_ADDR = '0;
        while (cyc < 40 && rsp_dat.size() < 4) begin
            if (RSP_VALID) begin rsp_cyc.push_back(cyc); rsp_dat.push_back(RSP_RDATA); end
            accepting = REQ_VALID && REQ_READY;
            if (accepting) acc_cyc[issued] = cyc;
            step(); cyc++;
            if (accepting) begin
                issued++;
                if (issued == 4) REQ_VALID = 1'b0;
                else REQ_ADDR = ADDR_W'(issued);
            end
        end
        REQ_VALID = 1'b0;
        vectors++;
        if (rsp_dat.size() !== 4 || issued !== 4) begin miscompares++;
            $display("FAIL b2b_count: rsp %0d issued %0d required 4", rsp_dat.size(), issued);
        end else begin
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if (rsp_dat[i] !== ref_mem[i]) begin miscompares++;
                    $display("FAIL b2b_data[%0d]: got %h required %h", i, rsp_dat[i], ref_mem[i]); end
                vectors++;
                if (rsp_cyc[i] !== acc_cyc[i] + 3) begin miscompares++;
                    $display("FAIL b2b_latency[%0d]: rsp at %0d required %0d", i, rsp_cyc[i], acc_cyc[i] + 3); end
                if (i > 0) begin
                    vectors++;
                    if (rsp_cyc[i] - rsp_cyc[i-1] !== 3) begin miscompares++;
                        $display("FAIL b2b_spacing[%0d]: got %0d required 3", i, rsp_cyc[i] - rsp_cyc[i-1]); end
                end
            end
            last_rd = rsp_dat[3];
        end
        step();
    endtask

    task automatic test_reset_rmw();
        int we0;
        xfer(1'b1, 2'b11, 12'h020, 16'h5566, "rst_rmw_pre");
        we0 = we_cnt;
        REQ_VALID = 1'b1; REQ_WE = 1'b1; REQ_BE = 2'b10; REQ_ADDR = 12'h020; REQ_WDATA = 16'hEE00;
        step();              // RD
        REQ_VALID = 1'b0;
        step();              // RDW
        RESET = 1'b1;
        step();
        vectors++;
        if ({RAM_nCS, RAM_nWE, RSP_VALID, REQ_READY} !== 4'b1100) begin miscompares++;
            $display("FAIL rst_rmw_ctrl: ncs/nwe/rsp/ready=%b required 1100",
                     {RAM_nCS, RAM_nWE, RSP_VALID, REQ_READY}); end
        vectors++;
        if (RAM_ADDR !== '0 || RAM_DI !== '0 || RSP_RDATA !== '0) begin miscompares++;
            $display("FAIL rst_rmw_data: addr=%h di=%h rdata=%h required 0", RAM_ADDR, RAM_DI, RSP_RDATA); end
        vectors++;
        if (we_cnt !== we0) begin miscompares++;
            $display("FAIL rst_rmw_nowrite: write strobes %0d required %0d", we_cnt, we0); end
        RESET = 1'b0;
        last_rd = 16'h0;
        #1;
        xfer(1'b0, 2'b11, 12'h020, 16'h0000, "rst_rmw_rd");
    endtask

    task automatic test_reset_wr();
        int we0;
        we0 = we_cnt;
        REQ_VALID = 1'b1; REQ_WE = 1'b1; REQ_BE = 2'b11; REQ_ADDR = 12'h030; REQ_WDATA = 16'h9999;
        step();              // WR
        REQ_VALID = 1'b0;
        RESET = 1'b1;
        step();
        vectors++;
        if (we_cnt !== we0 + 1) begin miscompares++;
            $display("FAIL rst_wr_commit: write strobes %0d required %0d", we_cnt, we0 + 1); end
        vectors++;
        if ({RAM_nCS, RSP_VALID, REQ_READY} !== 3'b100) begin miscompares++;
            $display("FAIL rst_wr_ctrl: ncs/rsp/ready=%b required 100", {RAM_nCS, RSP_VALID, REQ_READY}); end
        step();
        vectors++;
        if (RSP_VALID !== 1'b0) begin miscompares++;
            $display("FAIL rst_wr_rsp: rsp_valid=%b required 0", RSP_VALID); end
        RESET = 1'b0;
        ref_mem[12'h030] = 16'h9999;
        last_rd = 16'h0;
        #1;
        xfer(1'b0, 2'b11, 12'h030, 16'h0000, "rst_wr_rd");
    endtask

    task automatic test_random();
        logic [ADDR_W-1:0] a;
        for (int i = 0; i < 60; i++) begin
            a = ADDR_W'(12'h100 + $urandom_range(0, 7));
            xfer(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a, 16'($urandom), "rand");
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ref_mem[i] = 16'h0;
        last_rd = 16'h0;
        test_reset();
        test_full_write_read();
        test_partial_writes();
        test_back_to_back();
        test_reset_rmw();
        test_reset_wr();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ram_byte_ctrl.md
Name: ram_byte_ctrl

Overview:
- Request controller directly upstream of the 4096x16 synchronous RAM; it is the only master driving the RAM strobes.
- Accepts word or byte-lane requests from a CPU/loader over a valid/ready handshake.
- Sequences RAM chip-select and write-enable.
- Performs read-modify-write for partial (single-byte) writes, because the RAM has no byte enables.
- Returns read data with a one-cycle response pulse.

Parameters:
- ADDR_W, 12, word address width, passed straight through to the RAM.

Ports:
- CLK  in  1  single system clock; all state changes on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- REQ_VALID  in  1  request present.
- REQ_READY  out  1  controller can accept a request this cycle.
- REQ_WE  in  1  1 = write, 0 = read.
- REQ_BE  in  2  byte enables; [1] = bits 15:8 (even/high byte, big-endian), [0] = bits 7:0.
- REQ_ADDR  in  ADDR_W  word address.
- REQ_WDATA  in  16  write data.
- RSP_VALID  out  1  one-cycle pulse: RSP_RDATA holds read result.
- RSP_RDATA  out  16  read data; holds its value until the next read completes.
- RAM_nCS  out  1  RAM chip select, active low.
- RAM_nWE  out  1  RAM write enable, active low.
- RAM_ADDR  out  ADDR_W  RAM address.
- RAM_DI  out  16  RAM write data.
- RAM_DO  in  16  RAM read data; valid in the cycle after a read strobe.

Behaviour:
- All outputs are registered, except REQ_READY, which is decoded from the state register.
- Reset values: state IDLE, RAM_nCS=1, RAM_nWE=1, RAM_ADDR=0, RAM_DI=0, RSP_VALID=0, RSP_RDATA=0. REQ_READY=0 while RESET=1.
- Acceptance: REQ_READY=1 only in IDLE. A transfer occurs when REQ_VALID && REQ_READY; address, WE, BE and WDATA are latched at that edge (cycle N).
- States: IDLE, RD, RDW, MRG, WR.
- Read (any BE, full word returned):
  - N+1 RD: nCS=0, nWE=1.
  - N+2 RDW: RAM_DO captured into RSP_RDATA at end of cycle.
  - N+3: RSP_VALID=1 and state IDLE. Next accept possible in N+3.
- Full write (BE=11):
  - N+1 WR: nCS=0, nWE=0, RAM_DI=WDATA.
  - N+2: IDLE. No response pulse.
- Partial write (BE=10 or 01):
  - N+1 RD: strobe read.
  - N+2 RDW: merge at end of cycle; enabled lanes take WDATA, other lanes take RAM_DO.
  - N+3 WR: strobe write with merged word.
  - N+4: IDLE. No response pulse.
- BE=00 write: no RAM access; IDLE again at N+1.
- Strobes: nCS and nWE are low for exactly one cycle per access. nCS=1 in IDLE, RDW and MRG; RAM_ADDR and RAM_DI hold their last values there.
- RSP_VALID is exactly one cycle wide; no back-pressure on the response.
- REQ_VALID held high across busy cycles is accepted on the first IDLE cycle. Back-to-back reads produce responses every 3 cycles.
- Reset mid-operation:
  - Next edge returns to IDLE with strobes high; no response is issued.
  - A write whose WR cycle coincides with RESET=1 is committed, since the RAM samples at that same edge.
  - A partial write aborted before WR leaves memory unchanged.
- Address wrap: none. Address is passed unmodified.

Decomposition:
- ram_ctrl_pkg:
  - state enum (IDLE, RD, RDW, MRG, WR).
  - BE constants BE_NONE=2'b00, BE_LO=2'b01, BE_HI=2'b10, BE_WORD=2'b11.
  - RAM_DATA_W=16.
- Sub-module byte_merge: combinational; inputs old word, new word, BE; output merged word.

Test Plan:
- Full write 0x1234 @0x005, then read @0x005 -> nCS low one cycle each; RSP_VALID pulse 3 cycles after read accept; RSP_RDATA=0x1234.
- Write 0xAABB @0x010, then BE=10 write 0xCC00 @0x010, then read -> 0xCCBB. RMW takes 4 cycles; REQ_READY low N+1..N+3.
- Write 0xAABB @0x011, then BE=01 write 0x00DD, then read -> 0xAADD. Then BE=00 write 0xFFFF, then read -> still 0xAADD, with no nCS pulse for the BE=00 write.
- REQ_VALID held high with 4 reads @0x000..0x003 preloaded 0x1111..0x4444 -> responses every 3 cycles, in order, values 0x1111..0x4444.
- RESET asserted during RDW of partial write BE=10 0xEE00 @0x020 (old 0x5566) -> no write strobe; all outputs at reset values; read afterwards returns 0x5566.
- RESET asserted during WR of a full write 0x9999 @0x030 -> write committed; read returns 0x9999; RSP_VALID stays 0 during reset.
